digit_bounce_animator: RTL

- Upstream position source for the VGA seven-segment digit renderer; drives the digit's top-left (X,Y) so the digit bounces around the 640x480 visible area.
- Position changes only once per frame, in vertical blank, so a frame never tears mid-scan.
- Sits between video_timer (consumes xpos/ypos) and the seven-segment display unit (feeds Digit X/Y); runs in the clk25 domain.

---
 rtl/digit_anim_pkg.sv | 55 +++++
 rtl/frame_tick_gen.sv | 24 ++
 rtl/digit_bounce_animator.sv | 138 +++++++++++++
 3 files changed

// File: rtl/digit_anim_pkg.sv
// Shared constants, state encoding and per-axis bounce arithmetic for the digit animator.
package digit_anim_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } anim_state_e;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       bounce;
  } axis_t;

  function automatic logic [10:0] axis_max(input int unsigned visible, input int unsigned size);
    return 11'(visible - size);
  endfunction

  // 11-bit math so pos+step never wraps before the limit compare.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                      input logic [10:0] step, input logic [10:0] lim);
    axis_t      res;
    logic [10:0] w_pos;
    logic [10:0] w_sum;
    logic [10:0] w_dif;
    w_pos = {1'b0, pos};
    w_sum = w_pos + step;
    w_dif = w_pos - step;
    res.pos    = pos;
    res.dir    = dir;
    res.bounce = 1'b0;
    if (dir) begin
      if (w_sum >= lim) begin
        res.pos    = lim[9:0];
        res.bounce = 1'b1;
      end else begin
        res.pos = w_sum[9:0];
      end
    end else begin
      if (w_pos <= step) begin
        res.pos    = 10'd0;
        res.bounce = 1'b1;
      end else begin
        res.pos = w_dif[9:0];
      end
    end
    if (res.bounce) res.dir = ~dir;
    return res;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One registered pulse per frame, the cycle after the scan reaches (0, V_VISIBLE).
module frame_tick_gen #(
  parameter int unsigned V_VISIBLE = 480
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_xpos,
  input  logic [9:0] i_ypos,
  output logic       o_tick
);

  logic r_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= (i_xpos == 10'd0) && (i_ypos == 10'(V_VISIBLE));
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/digit_bounce_animator.sv
// Bounces the digit's top-left corner around the visible area, updating once per vertical blank.
// Optional DIGIT_ANIM_SPEED_EN adds a speed[1:0] input scaling the step by 1/2/4/8.
module digit_bounce_animator
  import digit_anim_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = SCREEN_W,
  parameter int unsigned V_VISIBLE   = SCREEN_H,
  parameter int unsigned DIGIT_W     = 32,
  parameter int unsigned DIGIT_H     = 48,
  parameter int unsigned INIT_X      = 200,
  parameter int unsigned INIT_Y      = 20,
  parameter int unsigned STEP        = 2,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
`ifdef DIGIT_ANIM_SPEED_EN
  input  logic [1:0] speed,
`endif
  output logic [9:0] digit_x,
  output logic [9:0] digit_y,
  output logic       dir_right,
  output logic       dir_down,
  output logic       corner_hit
);

  localparam logic [10:0] X_MAX = axis_max(H_VISIBLE, DIGIT_W);
  localparam logic [10:0] Y_MAX = axis_max(V_VISIBLE, DIGIT_H);

  logic        w_tick;
  logic [10:0] w_step;
  axis_t       w_ax;
  axis_t       w_ay;

  anim_state_e r_state, w_state_d;
  logic [7:0]  r_hold, w_hold_d;
  logic [9:0]  r_x, w_x_d;
  logic [9:0]  r_y, w_y_d;
  logic        r_right, w_right_d;
  logic        r_down, w_down_d;
  logic        r_corner, w_corner_d;

  frame_tick_gen #(
    .V_VISIBLE(V_VISIBLE)
  ) u_tick (
    .i_clk (clk25),
    .i_rst (reset),
    .i_xpos(xpos),
    .i_ypos(ypos),
    .o_tick(w_tick)
  );

`ifdef DIGIT_ANIM_SPEED_EN
  assign w_step = 11'(STEP) << speed;
`else
  assign w_step = 11'(STEP);
`endif

  assign w_ax = axis_step(r_x, r_right, w_step, X_MAX);
  assign w_ay = axis_step(r_y, r_down, w_step, Y_MAX);

  always_comb begin
    w_state_d  = r_state;
    w_hold_d   = r_hold;
    w_x_d      = r_x;
    w_y_d      = r_y;
    w_right_d  = r_right;
    w_down_d   = r_down;
    w_corner_d = 1'b0;
    if (load) begin
      w_x_d     = 10'(INIT_X);
      w_y_d     = 10'(INIT_Y);
      w_right_d = 1'b1;
      w_down_d  = 1'b1;
      w_hold_d  = 8'd0;
      w_state_d = enable ? S_RUN : S_IDLE;
    end else if (!enable) begin
      w_state_d = S_IDLE;
      w_hold_d  = 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_d = S_RUN;
        S_RUN: begin
          if (w_tick) begin
            w_x_d     = w_ax.pos;
            w_right_d = w_ax.dir;
            w_y_d     = w_ay.pos;
            w_down_d  = w_ay.dir;
            if (w_ax.bounce && w_ay.bounce) begin
              w_corner_d = 1'b1;
              w_hold_d   = 8'(HOLD_FRAMES);
              w_state_d  = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Counter reaching zero only re-arms; motion waits for the following tick.
          if (w_tick) begin
            if (r_hold == 8'd0) w_state_d = S_RUN;
            else                w_hold_d  = r_hold - 8'd1;
          end
        end
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_hold   <= 8'd0;
      r_x      <= 10'(INIT_X);
      r_y      <= 10'(INIT_Y);
      r_right  <= 1'b1;
      r_down   <= 1'b1;
      r_corner <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_hold   <= w_hold_d;
      r_x      <= w_x_d;
      r_y      <= w_y_d;
      r_right  <= w_right_d;
      r_down   <= w_down_d;
      r_corner <= w_corner_d;
    end
  end

  assign digit_x    = r_x;
  assign digit_y    = r_y;
  assign dir_right  = r_right;
  assign dir_down   = r_down;
  assign corner_hit = r_corner;

endmodule
